// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader for the ez8_cpu instruction memory.
//
// It receives bytes from a UART receiver. A frame is SYNC_BYTE, CNT_HI, CNT_LO,
// N 16-bit words sent high byte first, and CHK. CHK is the 8-bit sum of the
// data bytes. Each word is written to instruction memory, starting at address 0.
// cpu_hold is raised on the sync byte. It drops only on a good load or on reset,
// so a partially written or corrupt program never runs.
//
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   rx_data[7:0]    in   received byte, qualified by rx_valid
//   rx_valid        in   one-cycle strobe per received byte
//   instr_writeaddr out  instruction memory write address (ADDR_WIDTH bits)
//   instr_writedata out  16-bit instruction word
//   instr_write_en  out  one-cycle write strobe
//   cpu_hold        out  keeps the CPU paused and in reset
//   busy            out  high whenever a frame is in progress
//   load_ok         out  one-cycle pulse when a load completes with a good checksum
//   load_err        out  one-cycle pulse on a bad count, bad checksum or timeout
module instr_loader #(
  parameter int         ADDR_WIDTH     = 12,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [15:0]           instr_writedata,
  output logic                  instr_write_en,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_ok,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5
  } state_t;

  // The word index is one bit wider than the address. This lets a full-memory
  // load (N = 2**ADDR_WIDTH) count to its end without wrapping.
  localparam int              IW         = ADDR_WIDTH + 1;
  localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_WORDS  = 17'd1 << ADDR_WIDTH;

  state_t                state_reg, state_next;
  logic [7:0]            cnt_hi_reg, cnt_hi_next;
  logic [IW-1:0]         count_reg, count_next;
  logic [IW-1:0]         index_reg, index_next;
  logic [7:0]            sum_reg, sum_next;
  logic [7:0]            hi_reg, hi_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [15:0]           wr_data_reg, wr_data_next;
  logic                  hold_reg, hold_next;
  logic                  ok_reg, ok_next;
  logic                  err_reg, err_next;

  logic [15:0] word_count;
  logic        timeout;

  assign word_count = {cnt_hi_reg, rx_data};
  // The timeout takes priority over any byte that arrives in the same cycle.
  // That byte is dropped.
  assign timeout    = (state_reg != IDLE) && (timer_reg == TIMER_LAST);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_hi_reg  <= '0;
      count_reg   <= '0;
      index_reg   <= '0;
      sum_reg     <= '0;
      hi_reg      <= '0;
      timer_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      hold_reg    <= 1'b0;
      ok_reg      <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_hi_reg  <= cnt_hi_next;
      count_reg   <= count_next;
      index_reg   <= index_next;
      sum_reg     <= sum_next;
      hi_reg      <= hi_next;
      timer_reg   <= timer_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      hold_reg    <= hold_next;
      ok_reg      <= ok_next;
      err_reg     <= err_next;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_next   = state_reg;
    cnt_hi_next  = cnt_hi_reg;
    count_next   = count_reg;
    index_next   = index_reg;
    sum_next     = sum_reg;
    hi_next      = hi_reg;
    timer_next   = (state_reg == IDLE) ? '0 : timer_reg + TW'(1);
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    hold_next    = hold_reg;
    ok_next      = 1'b0;
    err_next     = 1'b0;

    if (timeout) begin
      err_next   = 1'b1;
      state_next = IDLE;
      timer_next = '0;
    end else if (rx_valid) begin
      timer_next = '0;
      case (state_reg)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_next = CNT_HI;
            hold_next  = 1'b1;
          end
        end
        CNT_HI: begin
          cnt_hi_next = rx_data;
          state_next  = CNT_LO;
        end
        CNT_LO: begin
          if ((word_count == 16'd0) || ({1'b0, word_count} > MAX_WORDS)) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            count_next = IW'(word_count);
            index_next = '0;
            sum_next   = '0;
            state_next = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_next    = rx_data;
          sum_next   = sum_reg + rx_data;
          state_next = DATA_LO;
        end
        DATA_LO: begin
          sum_next     = sum_reg + rx_data;
          wr_en_next   = 1'b1;
          wr_addr_next = index_reg[ADDR_WIDTH-1:0];
          wr_data_next = {hi_reg, rx_data};
          index_next   = index_reg + IW'(1);
          state_next   = (index_reg == count_reg - IW'(1)) ? CHECK : DATA_HI;
        end
        CHECK: begin
          state_next = IDLE;
          if (rx_data == sum_reg) begin
            ok_next   = 1'b1;
            hold_next = 1'b0;
          end else begin
            err_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs: every output comes straight from a register except busy.
  always_comb begin
    instr_write_en  = wr_en_reg;
    instr_writeaddr = wr_addr_reg;
    instr_writedata = wr_data_reg;
    cpu_hold        = hold_reg;
    load_ok         = ok_reg;
    load_err        = err_reg;
    busy            = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader. Bytes are driven on the falling edge.
// A falling-edge monitor logs writes and ok/err pulses with cycle stamps.
module tb_instr_loader;

  localparam int AW = 12;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] instr_writeaddr;
  logic [15:0]   instr_writedata;
  logic          instr_write_en;
  logic          cpu_hold;
  logic          busy;
  logic          load_ok;
  logic          load_err;

  always #5 clk = ~clk;

  instr_loader #(
    .ADDR_WIDTH(AW),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .instr_writeaddr(instr_writeaddr),
    .instr_writedata(instr_writedata),
    .instr_write_en(instr_write_en),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .load_ok(load_ok),
    .load_err(load_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  int            wc_q[$];
  int            ok_cnt = 0;
  int            err_cnt = 0;
  int            both_cnt = 0;
  int            err_cyc = 0;

  always @(negedge clk) begin
    if (instr_write_en) begin
      wa_q.push_back(instr_writeaddr);
      wd_q.push_back(instr_writedata);
      wc_q.push_back(cyc);
    end
    if (load_ok) ok_cnt++;
    if (load_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (load_ok && load_err) both_cnt++;
  end

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] tx_q[$];
  int         byte_cyc[$];
  int         gap = 1;
  int         w0, ok0, e0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send every byte in tx_q, starting at a falling edge. byte_cyc records the
  // cycle in which each byte was sampled.
  task automatic send_q();
    byte_cyc.delete();
    foreach (tx_q[i]) begin
      rx_data  = tx_q[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      byte_cyc.push_back(cyc);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic snap();
    w0  = wa_q.size();
    ok0 = ok_cnt;
    e0  = err_cnt;
  endtask

  function automatic logic [31:0] wa_at(input int i);
    if (i < wa_q.size()) return 32'(wa_q[i]);
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wd_at(input int i);
    if (i < wd_q.size()) return 32'(wd_q[i]);
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wc_at(input int i);
    if (i < wc_q.size()) return 32'(wc_q[i]);
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] bc_at(input int i);
    if (i < byte_cyc.size()) return 32'(byte_cyc[i]);
    return 32'hCAFE_F00D;
  endfunction

  task automatic check_quiet_outputs(input string pfx);
    check({pfx, "_we"},   32'(instr_write_en),  32'd0);
    check({pfx, "_addr"}, 32'(instr_writeaddr), 32'd0);
    check({pfx, "_data"}, 32'(instr_writedata), 32'd0);
    check({pfx, "_hold"}, 32'(cpu_hold),        32'd0);
    check({pfx, "_busy"}, 32'(busy),            32'd0);
    check({pfx, "_ok"},   32'(load_ok),         32'd0);
    check({pfx, "_err"},  32'(load_err),        32'd0);
  endtask

  logic [7:0]  sum8;
  logic [15:0] w16;
  int          bad;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_quiet_outputs("reset");

    // Good load of two words. The checksum is 12+34+AB+CD mod 256 = BE.
    snap();
    tx_q = '{8'hA5};
    send_q();
    check("sync_hold", 32'(cpu_hold), 32'd1);
    check("sync_busy", 32'(busy), 32'd1);
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_q();
    idle(2);
    check("good_nwr",   32'(wa_q.size() - w0), 32'd2);
    check("good_a0",    wa_at(w0),     32'h000);
    check("good_d0",    wd_at(w0),     32'h1234);
    check("good_a1",    wa_at(w0 + 1), 32'h001);
    check("good_d1",    wd_at(w0 + 1), 32'hABCD);
    check("good_lat0",  wc_at(w0),     bc_at(3));
    check("good_lat1",  wc_at(w0 + 1), bc_at(5));
    check("good_ok",    32'(ok_cnt - ok0), 32'd1);
    check("good_err",   32'(err_cnt - e0), 32'd0);
    check("good_hold",  32'(cpu_hold), 32'd0);
    check("good_busy",  32'(busy), 32'd0);

    // Bad checksum: both writes still happen, load_err fires, and the hold stays set.
    snap();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
    send_q();
    idle(2);
    check("badchk_nwr",  32'(wa_q.size() - w0), 32'd2);
    check("badchk_err",  32'(err_cnt - e0), 32'd1);
    check("badchk_ok",   32'(ok_cnt - ok0), 32'd0);
    check("badchk_hold", 32'(cpu_hold), 32'd1);

    // The same good frame sent with back-to-back strobes clears the hold.
    gap = 0;
    snap();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_q();
    gap = 1;
    idle(2);
    check("b2b_ok",   32'(ok_cnt - ok0), 32'd1);
    check("b2b_hold", 32'(cpu_hold), 32'd0);
    check("b2b_d0",   wd_at(w0), 32'h1234);
    check("b2b_d1",   wd_at(w0 + 1), 32'hABCD);
    check("b2b_lat1", wc_at(w0 + 1), bc_at(6));

    // N = 0
    snap();
    tx_q = '{8'hA5, 8'h00, 8'h00};
    send_q();
    idle(2);
    check("n0_err",     32'(err_cnt - e0), 32'd1);
    check("n0_errtime", 32'(err_cyc), bc_at(2));
    check("n0_nwr",     32'(wa_q.size() - w0), 32'd0);
    check("n0_hold",    32'(cpu_hold), 32'd1);
    check("n0_busy",    32'(busy), 32'd0);

    // N = 4097 is one word too many.
    snap();
    tx_q = '{8'hA5, 8'h10, 8'h01};
    send_q();
    idle(2);
    check("n4097_err",  32'(err_cnt - e0), 32'd1);
    check("n4097_nwr",  32'(wa_q.size() - w0), 32'd0);
    check("n4097_busy", 32'(busy), 32'd0);

    // N = 4096 fills the whole memory. Word i holds the value i.
    snap();
    tx_q = '{8'hA5, 8'h10, 8'h00};
    sum8 = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      w16 = 16'(i);
      tx_q.push_back(w16[15:8]);
      tx_q.push_back(w16[7:0]);
      sum8 = sum8 + w16[15:8] + w16[7:0];
    end
    tx_q.push_back(sum8);
    send_q();
    idle(2);
    check("full_nwr", 32'(wa_q.size() - w0), 32'd4096);
    bad = 0;
    if (wa_q.size() - w0 == 4096) begin
      for (int i = 0; i < 4096; i++) begin
        w16 = 16'(i);
        if (wa_at(w0 + i) !== 32'(w16[11:0]) || wd_at(w0 + i) !== 32'(w16)) bad++;
      end
    end else begin
      bad = -1;
    end
    check("full_contents", 32'(bad), 32'd0);
    check("full_last_a", wa_at(w0 + 4095), 32'hFFF);
    check("full_last_d", wd_at(w0 + 4095), 32'h0FFF);
    check("full_ok",     32'(ok_cnt - ok0), 32'd1);
    check("full_hold",   32'(cpu_hold), 32'd0);

    // Timeout after the first data byte
    snap();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_q();
    idle(120);
    check("to_err",     32'(err_cnt - e0), 32'd1);
    check("to_latency", 32'(err_cyc) - bc_at(3), 32'd100);
    check("to_nwr",     32'(wa_q.size() - w0), 32'd0);
    check("to_busy",    32'(busy), 32'd0);
    check("to_hold",    32'(cpu_hold), 32'd1);

    // Noise in IDLE, then a frame whose data bytes equal the sync byte
    snap();
    tx_q = '{8'h00, 8'hFF, 8'h5A};
    send_q();
    check("noise_busy", 32'(busy), 32'd0);
    check("noise_nwr",  32'(wa_q.size() - w0), 32'd0);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h4A};
    send_q();
    idle(2);
    check("sync_data_nwr", 32'(wa_q.size() - w0), 32'd1);
    check("sync_data_a",   wa_at(w0), 32'h000);
    check("sync_data_d",   wd_at(w0), 32'hA5A5);
    check("sync_data_ok",  32'(ok_cnt - ok0), 32'd1);

    // Reset mid-frame after the first data byte
    snap();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_q();
    check("pre_rst_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b1;
    idle(1);
    check_quiet_outputs("midrst");
    reset = 1'b0;
    tx_q = '{8'h34};
    send_q();
    idle(2);
    check("midrst_nwr", 32'(wa_q.size() - w0), 32'd0);
    snap();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'hCE};
    send_q();
    idle(2);
    check("after_rst_d",    wd_at(w0), 32'h5678);
    check("after_rst_a",    wa_at(w0), 32'h000);
    check("after_rst_ok",   32'(ok_cnt - ok0), 32'd1);
    check("after_rst_hold", 32'(cpu_hold), 32'd0);

    check("ok_err_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
